// File: rtl/gpu_pkg.sv
// Shared core-state and fetcher-state encodings.
// Used by the PC, decoder, scheduler and fetch stage.
package gpu_pkg;

  localparam logic [2:0] CORE_IDLE    = 3'b000;
  localparam logic [2:0] CORE_FETCH   = 3'b001;
  localparam logic [2:0] CORE_DECODE  = 3'b010;
  localparam logic [2:0] CORE_REQUEST = 3'b011;
  localparam logic [2:0] CORE_WAIT    = 3'b100;
  localparam logic [2:0] CORE_EXECUTE = 3'b101;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;
  localparam logic [2:0] CORE_DONE    = 3'b111;

  typedef enum logic [2:0] {
    FETCHER_IDLE     = 3'b000,
    FETCHER_FETCHING = 3'b001,
    FETCHER_FETCHED  = 3'b010
  } fetcher_state_e;

endpackage

// File: rtl/fetcher_icache_array.sv
// Direct-mapped line storage: valid/tag/data per line.
// Ports: comb read (rd_idx), one write port, sync flush.
module icache_array #(
  parameter int LINES  = 16,
  parameter int IDX_W  = 4,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data
);

  logic [LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [TAG_W-1:0]  tag_d  [LINES];
  logic [DATA_W-1:0] data_q [LINES];
  logic [DATA_W-1:0] data_d [LINES];

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

  // Flush beats a same-cycle fill: the line stays invalid.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
      tag_d[wr_idx]   = wr_tag;
      data_d[wr_idx]  = wr_data;
    end
    if (flush) valid_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) valid_q <= '0;
    else       valid_q <= valid_d;
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/fetcher_icache.sv
// Fetch stage with direct-mapped icache and mem handshake.
// Ports: core_state/current_pc/flush in; mem req/resp; state, instr, counters out.
module fetcher_icache
  import gpu_pkg::*;
#(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16,
  parameter int CACHE_LINES           = 16,
  parameter int CNT_BITS              = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             flush,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic [CNT_BITS-1:0]              hit_count,
  output logic [CNT_BITS-1:0]              miss_count
);

  localparam int AW    = PROGRAM_MEM_ADDR_BITS;
  localparam int DW    = PROGRAM_MEM_DATA_BITS;
  localparam int IDX_W = $clog2(CACHE_LINES);
  localparam int TAG_W = AW - IDX_W;

  fetcher_state_e  state_q, state_d;
  logic            req_q, req_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   instr_q, instr_d;
  logic [CNT_BITS-1:0] hit_q, hit_d;
  logic [CNT_BITS-1:0] miss_q, miss_d;

  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [DW-1:0]    rd_data;
  logic             wr_en;
  logic             hit;

  icache_array #(
    .LINES  (CACHE_LINES),
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W),
    .DATA_W (DW)
  ) u_array (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .rd_idx   (current_pc[IDX_W-1:0]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_idx   (addr_q[IDX_W-1:0]),
    .wr_tag   (addr_q[AW-1:IDX_W]),
    .wr_data  (mem_read_data)
  );

  assign hit = rd_valid && (rd_tag == current_pc[AW-1:IDX_W]);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    hit_d   = hit_q;
    miss_d  = miss_q;
    wr_en   = 1'b0;
    unique case (state_q)
      FETCHER_IDLE: begin
        if (core_state == CORE_FETCH) begin
          if (hit) begin
            instr_d = rd_data;
            state_d = FETCHER_FETCHED;
            if (hit_q != '1) hit_d = hit_q + 1'b1;
          end else begin
            req_d   = 1'b1;
            addr_d  = current_pc;
            state_d = FETCHER_FETCHING;
            if (miss_q != '1) miss_d = miss_q + 1'b1;
          end
        end
      end
      FETCHER_FETCHING: begin
        if (mem_read_ready) begin
          instr_d = mem_read_data;
          wr_en   = 1'b1;
          req_d   = 1'b0;
          state_d = FETCHER_FETCHED;
        end
      end
      FETCHER_FETCHED: begin
        if (core_state == CORE_DECODE) state_d = FETCHER_IDLE;
      end
      default: state_d = FETCHER_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCHER_IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      instr_q <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  assign mem_read_valid   = req_q;
  assign mem_read_address = addr_q;
  assign fetcher_state    = state_q;
  assign instruction      = instr_q;
  assign hit_count        = hit_q;
  assign miss_count       = miss_q;

endmodule

// File: doc/fetcher_icache.md
Name: fetcher_icache

Overview:
- Instruction fetch stage of each core, directly upstream of the decoder and PC stage.
- Holds current_pc (produced by the PC stage as next_pc) and returns the 16-bit instruction word.
- Contains a small direct-mapped instruction cache. Hits complete in one cycle; misses go to program memory over a valid/ready handshake.
- Reports progress to the core scheduler through fetcher_state.

Parameters:
- PROGRAM_MEM_ADDR_BITS, 8, width of the PC and the program memory address.
- PROGRAM_MEM_DATA_BITS, 16, instruction word width.
- CACHE_LINES, 16, number of one-word lines. Must be a power of 2, ≥2 and ≤2^PROGRAM_MEM_ADDR_BITS.
- CNT_BITS, 16, width of the hit and miss counters.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- core_state  input  3  scheduler state: FETCH=3'b001, DECODE=3'b010.
- current_pc  input  PROGRAM_MEM_ADDR_BITS  address to fetch.
- flush  input  1  invalidates all cache lines (kernel start or program reload).
- mem_read_valid  output  1  program memory request is pending.
- mem_read_address  output  PROGRAM_MEM_ADDR_BITS  request address.
- mem_read_ready  input  1  memory data is valid this cycle.
- mem_read_data  input  PROGRAM_MEM_DATA_BITS  returned instruction.
- fetcher_state  output  3  IDLE=3'b000, FETCHING=3'b001, FETCHED=3'b010.
- instruction  output  PROGRAM_MEM_DATA_BITS  fetched instruction, stable while in FETCHED.
- hit_count  output  CNT_BITS  saturating count of cache hits.
- miss_count  output  CNT_BITS  saturating count of cache misses.

Behaviour:
- Address split: IDX=log2(CACHE_LINES) bits. index=current_pc[IDX-1:0]; tag=current_pc[ADDR-1:IDX]. Per line: valid bit, tag, data.
- Reset: fetcher_state=IDLE, mem_read_valid=0, mem_read_address=0, instruction=0, all valid bits=0, both counters=0. Reset mid-miss drops the request immediately (valid deasserts the next cycle); no line is filled.
- IDLE with core_state==FETCH, hit (valid[index] && tag match):
  - instruction<=data[index]; state->FETCHED; hit_count+1.
  - Latency is 1 cycle and no memory request is issued.
- IDLE with core_state==FETCH, miss:
  - mem_read_valid<=1; mem_read_address<=current_pc; state->FETCHING; miss_count+1.
- IDLE with core_state not FETCH: hold; no request, no counting.
- FETCHING:
  - mem_read_valid and mem_read_address held constant until mem_read_ready.
  - On the ready cycle: instruction<=mem_read_data; line[index of mem_read_address] is filled (valid=1, tag, data); mem_read_valid<=0; state->FETCHED.
  - Minimum miss latency is 2 cycles (request, then ready). mem_read_ready seen while not FETCHING is ignored.
- FETCHED:
  - instruction is held.
  - core_state==DECODE -> IDLE the next cycle. Any other core_state holds FETCHED.
  - A new fetch needs a return to IDLE first, so one FETCH lookup is made per instruction.
- flush:
  - Clears all valid bits the next edge, in any state.
  - If flush coincides with a miss fill, flush wins: the line ends invalid, but instruction still takes mem_read_data and the state still goes FETCHED.
  - If flush coincides with an IDLE lookup, the lookup uses the pre-flush contents.
  - A flush does not abort a pending memory request.
- Counters saturate at all-ones and never wrap.
- Replacement: a fill overwrites the indexed line unconditionally (conflict eviction).
- current_pc is sampled only at the IDLE lookup. Changes during FETCHING or FETCHED are ignored.

Decomposition:
- Shared package gpu_pkg: core_state localparams (IDLE..DONE, 3'b000..3'b111) and fetcher_state localparams IDLE/FETCHING/FETCHED. The PC, decoder and scheduler already need these encodings.
- One sub-module, icache_array: valid/tag/data storage with a combinational read port, one write port, and a synchronous flush input.
- fetcher_icache holds the FSM, the memory handshake and the counters.

Test Plan:
- Cold miss: after reset, FETCH with pc=0x05 -> mem_read_valid=1 with addr 0x05 next cycle. Ready 3 cycles later with data 0x1234 -> instruction=0x1234, state FETCHED, miss_count=1.
- Hit: DECODE, then FETCH pc=0x05 again -> FETCHED after one cycle, instruction=0x1234, mem_read_valid stays 0, hit_count=1.
- Conflict: pc=0x15 (same index 5, tag 1) misses. Fill 0xABCD, then refetch pc=0x05 -> miss again and miss_count=3.
- Flush: flush asserted in FETCHED, then FETCH pc=0x15 -> miss. Flush on the ready cycle of that miss -> instruction=fill data, and the following FETCH of 0x15 misses again.
- Reset mid-miss: reset while FETCHING -> next cycle mem_read_valid=0, state IDLE, counters 0. A late mem_read_ready is ignored.
- Saturation and stall: preload hit_count near max by repeated hits with CNT_BITS=4 -> holds 15. Core_state held at WAIT in FETCHED -> state and instruction unchanged.
